// File: rtl/mem_wr_arb_if.sv
// Handshake bundle for mem_wr_arb: per-channel write requests in, one memory write port out.
// The slave modport is the arbiter's view; the master modport drives requests and consumes writes.
interface mem_wr_arb_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8,
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        s_valid;
    logic [NUM_CH-1:0]        s_ready;
    logic [NUM_CH*ADDR_W-1:0] s_addr;
    logic [NUM_CH*WIDTH-1:0]  s_data;
    logic                     m_write;
    logic [ADDR_W-1:0]        m_addr;
    logic [WIDTH-1:0]         m_data;
    logic [CH_W-1:0]          m_ch;
    logic                     m_ready;

    modport slave (
        input  s_valid, s_addr, s_data, m_ready,
        output s_ready, m_write, m_addr, m_data, m_ch
    );

    modport master (
        output s_valid, s_addr, s_data, m_ready,
        input  s_ready, m_write, m_addr, m_data, m_ch
    );
endinterface

// File: rtl/mem_wr_arb.sv
// Round-robin write arbiter: grants one of NUM_CH request channels into a single
// registered memory-write slot with valid/ready flow control on both sides.
module mem_wr_arb #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8,
    parameter int NUM_CH = 4,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic         clk,
    input  logic         reset_p,
    mem_wr_arb_if.slave  bus
);
    logic [CH_W-1:0]   ptr;
    logic              slot_write;
    logic [ADDR_W-1:0] slot_addr;
    logic [WIDTH-1:0]  slot_data;
    logic [CH_W-1:0]   slot_ch;

    logic              load_en;
    logic [NUM_CH-1:0] above;
    logic [NUM_CH-1:0] hi_req;
    logic              gnt_any;
    logic [CH_W-1:0]   gnt_idx;
    logic [NUM_CH-1:0] grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_data;

    assign load_en = !slot_write || bus.m_ready;

    // Requests above ptr win first; otherwise wrap to the lowest requester.
    always_comb begin
        above   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            above[i] = (i > 32'(ptr));
        end
        hi_req = bus.s_valid & above;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!gnt_any && hi_req[i]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!gnt_any && bus.s_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(i);
            end
        end
    end

    always_comb begin
        grant    = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            grant[i] = gnt_any && (gnt_idx == CH_W'(i));
            if (grant[i]) begin
                sel_addr = bus.s_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.s_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.s_ready = (load_en && !reset_p) ? grant : '0;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            slot_write <= 1'b0;
            slot_addr  <= '0;
            slot_data  <= '0;
            slot_ch    <= '0;
            ptr        <= CH_W'(NUM_CH - 1);
        end else if (load_en) begin
            if (gnt_any) begin
                slot_write <= 1'b1;
                slot_addr  <= sel_addr;
                slot_data  <= sel_data;
                slot_ch    <= gnt_idx;
                ptr        <= gnt_idx;
            end else begin
                slot_write <= 1'b0;
            end
        end
    end

    assign bus.m_write = slot_write;
    assign bus.m_addr  = slot_addr;
    assign bus.m_data  = slot_data;
    assign bus.m_ch    = slot_ch;
endmodule

// File: tb/tb_mem_wr_arb.sv
// Bench for mem_wr_arb: directed vector table, a stall/data-hold sequence, and a
// randomized run against a round-robin queue reference model.
module tb_mem_wr_arb;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 8;
    localparam int NUM_CH = 4;

    logic clk = 1'b0;
    logic reset_p;
    always #5 clk = ~clk;

    mem_wr_arb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) bus ();

    mem_wr_arb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [7:0]  ch_addr [NUM_CH] = '{8'h10, 8'h21, 8'h33, 8'h44};
    logic [15:0] ch_data [NUM_CH] = '{16'hA5A5, 16'h1234, 16'h5A5A, 16'hBEEF};

    task automatic load_const();
        for (int i = 0; i < NUM_CH; i++) begin
            bus.s_addr[i*ADDR_W +: ADDR_W] = ch_addr[i];
            bus.s_data[i*WIDTH +: WIDTH]   = ch_data[i];
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       mready;
        logic [3:0] exp_sready;
        logic       exp_mwrite;
        logic [1:0] exp_ch;
    } vec_t;

    vec_t vt[$];

    typedef struct {
        int          ch;
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t q[$];

    initial begin
        reset_p     = 1'b1;
        bus.s_valid = '0;
        bus.m_ready = 1'b0;
        load_const();

        // rst, valid, m_ready, s_ready before edge, m_write / m_ch after edge
        vt.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0});
        vt.push_back('{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0});
        vt.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0});
        vt.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0});
        for (int k = 0; k < 8; k++)
            vt.push_back('{1'b0, 4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b1, 2'(k % 4)});
        vt.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0});
        vt.push_back('{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1});
        vt.push_back('{1'b0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3});
        vt.push_back('{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1});
        vt.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0});
        vt.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2});
        for (int k = 0; k < 3; k++)
            vt.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2});
        vt.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3});
        vt.push_back('{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1});
        vt.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1});
        vt.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0});
        vt.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0});
        vt.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0});

        foreach (vt[k]) begin
            reset_p     = vt[k].rst;
            bus.s_valid = vt[k].valid;
            bus.m_ready = vt[k].mready;
            #1;
            check($sformatf("vec%0d s_ready", k), 32'(bus.s_ready), 32'(vt[k].exp_sready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d m_write", k), 32'(bus.m_write), 32'(vt[k].exp_mwrite));
            if (vt[k].exp_mwrite) begin
                check($sformatf("vec%0d m_ch", k),   32'(bus.m_ch),   32'(vt[k].exp_ch));
                check($sformatf("vec%0d m_addr", k), 32'(bus.m_addr), 32'(ch_addr[vt[k].exp_ch]));
                check($sformatf("vec%0d m_data", k), 32'(bus.m_data), 32'(ch_data[vt[k].exp_ch]));
            end else if (vt[k].rst) begin
                check($sformatf("vec%0d rst m_ch", k),   32'(bus.m_ch),   32'h0);
                check($sformatf("vec%0d rst m_addr", k), 32'(bus.m_addr), 32'h0);
                check($sformatf("vec%0d rst m_data", k), 32'(bus.m_data), 32'h0);
            end
        end

        // Slot holds ch0; new ch0 payload must not leak in while stalled.
        reset_p     = 1'b0;
        bus.m_ready = 1'b0;
        bus.s_valid = 4'b0001;
        bus.s_addr[0 +: ADDR_W] = 8'hEE;
        bus.s_data[0 +: WIDTH]  = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("stall s_ready", 32'(bus.s_ready), 32'h0);
            @(posedge clk);
            #1;
            check("stall m_addr", 32'(bus.m_addr), 32'h10);
            check("stall m_data", 32'(bus.m_data), 32'hA5A5);
        end
        bus.m_ready = 1'b1;
        #1;
        check("release s_ready", 32'(bus.s_ready), 32'h1);
        @(posedge clk);
        #1;
        check("release m_addr", 32'(bus.m_addr), 32'hEE);
        check("release m_data", 32'(bus.m_data), 32'hFFFF);
        bus.s_valid = '0;
        load_const();
        @(posedge clk);
        #1;
        check("drain m_write", 32'(bus.m_write), 32'h0);

        begin
            bit          mw;
            int          mc, mptr, g, c;
            logic [7:0]  ma;
            logic [15:0] md;
            bit          r, mr, le;
            logic [3:0]  v;
            int          exp_sr;
            wr_t         w;
            mw = 0; mc = 0; mptr = NUM_CH - 1; ma = '0; md = '0;
            for (int cyc = 0; cyc < 10000; cyc++) begin
                r  = (cyc == 0) || ($urandom_range(0, 499) == 0);
                v  = 4'($urandom_range(0, 15));
                mr = ($urandom_range(0, 3) != 0);
                reset_p     = r;
                bus.s_valid = v;
                bus.m_ready = mr;
                bus.s_addr  = $urandom;
                bus.s_data  = {$urandom, $urandom};
                #1;
                le = !mw || mr;
                g  = -1;
                for (int k = 1; k <= NUM_CH; k++) begin
                    c = (mptr + k) % NUM_CH;
                    if (g < 0 && v[c]) g = c;
                end
                exp_sr = (!r && le && g >= 0) ? (1 << g) : 0;
                check("rnd s_ready", 32'(bus.s_ready), 32'(exp_sr));
                check("rnd m_write", 32'(bus.m_write), 32'(mw));
                if (bus.m_write && mr) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rnd spurious write: got ch %0d expected no write", bus.m_ch);
                    end else begin
                        w = q.pop_front();
                        check("rnd done ch",   32'(bus.m_ch),   32'(w.ch));
                        check("rnd done addr", 32'(bus.m_addr), 32'(w.a));
                        check("rnd done data", 32'(bus.m_data), 32'(w.d));
                    end
                end
                if (exp_sr != 0)
                    q.push_back('{g, bus.s_addr[g*ADDR_W +: ADDR_W], bus.s_data[g*WIDTH +: WIDTH]});
                @(posedge clk);
                #1;
                if (r) begin
                    mw = 0;
                    mptr = NUM_CH - 1;
                    q.delete();
                end else if (le) begin
                    if (g >= 0) begin
                        mw   = 1;
                        mc   = g;
                        mptr = g;
                        ma   = q[q.size()-1].a;
                        md   = q[q.size()-1].d;
                    end else begin
                        mw = 0;
                    end
                end
                if (mw) begin
                    check("rnd slot ch",   32'(bus.m_ch),   32'(mc));
                    check("rnd slot addr", 32'(bus.m_addr), 32'(ma));
                    check("rnd slot data", 32'(bus.m_data), 32'(md));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
